// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multicycle divider.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder stays below the divisor, so the WIDTH+1-bit trial sign is exact.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[WIDTH] == 1'b0) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multicycle signed divider (MIPS DIV): quotient to LO, remainder to HI, one quotient bit per clock.
module div_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             initDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             divBusy,
    output logic             divDone,
    output logic             divZero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_rem, step_quo;

    // Magnitudes as unsigned WIDTH bits, so -2^WIDTH-1 maps cleanly to 2^WIDTH-1.
    assign a_abs = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign b_abs = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (initDiv) state_d = (B == '0) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt_q == LAST_CNT) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (initDiv) begin
                    zero_d = (B == '0);
                    if (B != '0) begin
                        quo_d    = a_abs;
                        dvs_d    = b_abs;
                        sign_a_d = A[WIDTH-1];
                        sign_b_d = B[WIDTH-1];
                        rem_d    = '0;
                        cnt_d    = '0;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Quotient truncates toward zero; remainder takes the dividend's sign.
            DIV_FIX: begin
                lo_d = (sign_a_q ^ sign_b_q) ? (~quo_q + WIDTH'(1)) : quo_q;
                hi_d = sign_a_q ? (~rem_q + WIDTH'(1)) : rem_q;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        divBusy = (state_q == DIV_CALC) || (state_q == DIV_FIX);
        divDone = (state_q == DIV_DONE);
        divZero = (state_q == DIV_DONE) && zero_q;
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq with hand-computed quotients and remainders.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        initDiv;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        divBusy;
    logic        divDone;
    logic        divZero;

    int compareCount = 0;
    int failCount    = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .initDiv (initDiv),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .divBusy (divBusy),
        .divDone (divDone),
        .divZero (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Holds initDiv for one sampling edge, then scrambles A/B to prove they were latched.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A       = a;
        B       = b;
        initDiv = 1'b1;
        @(negedge clk);
        initDiv = 1'b0;
        A       = 32'hDEADBEEF;
        B       = 32'h00000001;
    endtask

    task automatic runCase(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int pulseAt, input int expDoneAt, input int expBusy,
                           input logic expZero, input logic [31:0] expLo, input logic [31:0] expHi);
        int   n;
        int   doneAt;
        int   busyCnt;
        logic zeroSeen;
        applyStimulus(a, b);
        n        = 1;
        doneAt   = -1;
        busyCnt  = 0;
        zeroSeen = 1'b0;
        while (n <= 40 && doneAt < 0) begin
            if (pulseAt != 0 && n == pulseAt) begin
                A       = 32'd9;
                B       = 32'd3;
                initDiv = 1'b1;
            end else if (pulseAt != 0 && n == pulseAt + 1) begin
                initDiv = 1'b0;
            end
            if (divDone) begin
                doneAt   = n;
                zeroSeen = divZero;
            end else begin
                if (divBusy) busyCnt++;
                @(negedge clk);
                n++;
            end
        end
        initDiv = 1'b0;
        checkOutput({name, " doneAt"}, 32'(doneAt), 32'(expDoneAt));
        checkOutput({name, " busyCycles"}, 32'(busyCnt), 32'(expBusy));
        checkOutput({name, " divZero"}, {31'd0, zeroSeen}, {31'd0, expZero});
        @(negedge clk);
        checkOutput({name, " donePulseEnd"}, {31'd0, divDone}, 32'd0);
        checkOutput({name, " zeroPulseEnd"}, {31'd0, divZero}, 32'd0);
        checkOutput({name, " LO"}, LO, expLo);
        checkOutput({name, " HI"}, HI, expHi);
    endtask

    initial begin
        reset   = 1'b0;
        initDiv = 1'b0;
        A       = '0;
        B       = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        checkOutput("reset divBusy", {31'd0, divBusy}, 32'd0);
        checkOutput("reset divDone", {31'd0, divDone}, 32'd0);
        checkOutput("reset divZero", {31'd0, divZero}, 32'd0);
        reset = 1'b1;

        runCase("100/7",    32'd100,        32'd7,          0, 34, 33, 1'b0, 32'd14,       32'd2);
        runCase("-100/7",   32'hFFFFFF9C,   32'd7,          0, 34, 33, 1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE);
        runCase("100/-7",   32'd100,        32'hFFFFFFF9,   0, 34, 33, 1'b0, 32'hFFFFFFF2, 32'd2);
        runCase("5/0",      32'd5,          32'd0,          0, 1,  0,  1'b1, 32'hFFFFFFF2, 32'd2);
        runCase("min/-1",   32'h80000000,   32'hFFFFFFFF,   0, 34, 33, 1'b0, 32'h80000000, 32'd0);
        runCase("-1/min",   32'hFFFFFFFF,   32'h80000000,   0, 34, 33, 1'b0, 32'd0,        32'hFFFFFFFF);
        runCase("1000/3",   32'd1000,       32'd3,          6, 34, 33, 1'b0, 32'd333,      32'd1);

        applyStimulus(32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midReset HI", HI, 32'd0);
        checkOutput("midReset LO", LO, 32'd0);
        checkOutput("midReset divBusy", {31'd0, divBusy}, 32'd0);
        checkOutput("midReset divDone", {31'd0, divDone}, 32'd0);
        checkOutput("midReset divZero", {31'd0, divZero}, 32'd0);
        reset = 1'b1;

        runCase("49/7",     32'd49,         32'd7,          0, 34, 33, 1'b0, 32'd7,        32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
